// File: rtl/traffic_ctrl_multi_if.sv
// Lamp/display bundle between the tick source, the controller and the LED drivers.
// The master side supplies tick/req/night; the slave (the controller) drives the lamps.
interface traffic_ctrl_multi_if #(
  parameter int N_DIR = 2,
  parameter int CNT_W = 6
);
  logic             tick;
  logic [N_DIR-1:0] req;
  logic             night;
  logic [N_DIR-1:0] red;
  logic [N_DIR-1:0] yellow;
  logic [N_DIR-1:0] green;
  logic [1:0]       active_dir;
  logic [CNT_W-1:0] countdown;
  logic             blank;

  modport master (
    output tick, req, night,
    input  red, yellow, green, active_dir, countdown, blank
  );

  modport slave (
    input  tick, req, night,
    output red, yellow, green, active_dir, countdown, blank
  );
endinterface

// File: rtl/traffic_ctrl_multi.sv
// Multi-approach traffic-light sequencer: round-robin green with demand skipping,
// all-red clearance between approaches and a flashing-yellow night mode.
module traffic_ctrl_multi #(
  parameter int N_DIR    = 2,
  parameter int GREEN_S  = 20,
  parameter int YELLOW_S = 3,
  parameter int ALLRED_S = 2,
  parameter int CNT_W    = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  traffic_ctrl_multi_if.slave  bus
);
  typedef enum logic [1:0] {ALLRED, GREEN, YELLOW, FLASH} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [1:0]       dir_reg, dir_next, sel_dir;
  logic             phase_reg, phase_next;
  logic [N_DIR-1:0] pending_reg, pending_next, pend_eff, green_now, clr_mask;
  logic [N_DIR-1:0] red_reg, yellow_reg, green_reg;
  logic [N_DIR-1:0] red_next, yellow_next, green_next;
  logic             blank_reg, blank_next;

  function automatic logic [N_DIR-1:0] onehot(input logic [1:0] d);
    return N_DIR'(1) << d;
  endfunction

  function automatic logic [1:0] wrap_inc(input logic [1:0] d, input int k);
    int s;
    s = (int'(d) + k) % N_DIR;
    return 2'(s);
  endfunction

  // A req on the transition edge still competes for the next green.
  assign pend_eff = pending_reg | bus.req;

  // Scan from the highest offset down so the nearest requesting direction wins;
  // offset N_DIR is the current direction itself, hence considered last.
  always_comb begin
    sel_dir = wrap_inc(dir_reg, 1);
    for (int k = N_DIR; k >= 1; k--) begin
      if (|(pend_eff & onehot(wrap_inc(dir_reg, k))))
        sel_dir = wrap_inc(dir_reg, k);
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    dir_next   = dir_reg;
    phase_next = phase_reg;
    if (bus.tick) begin
      case (state_reg)
        ALLRED: begin
          if (cnt_reg == CNT_W'(1)) begin
            if (bus.night) begin
              state_next = FLASH;
              cnt_next   = '0;
              phase_next = 1'b0;
            end else begin
              state_next = GREEN;
              cnt_next   = CNT_W'(GREEN_S);
              dir_next   = sel_dir;
            end
          end else begin
            cnt_next = cnt_reg - CNT_W'(1);
          end
        end
        GREEN: begin
          if (cnt_reg == CNT_W'(1)) begin
            state_next = YELLOW;
            cnt_next   = CNT_W'(YELLOW_S);
          end else begin
            cnt_next = cnt_reg - CNT_W'(1);
          end
        end
        YELLOW: begin
          if (cnt_reg == CNT_W'(1)) begin
            state_next = ALLRED;
            cnt_next   = CNT_W'(ALLRED_S);
          end else begin
            cnt_next = cnt_reg - CNT_W'(1);
          end
        end
        FLASH: begin
          if (!bus.night) begin
            state_next = ALLRED;
            cnt_next   = CNT_W'(ALLRED_S);
            phase_next = 1'b0;
          end else begin
            phase_next = ~phase_reg;
          end
        end
        default: state_next = ALLRED;
      endcase
    end
  end

  // Lamps are decoded from the next state so they change on the same edge as the state.
  always_comb begin
    red_next    = '0;
    yellow_next = '0;
    green_next  = '0;
    blank_next  = 1'b0;
    case (state_next)
      ALLRED: red_next = '1;
      GREEN: begin
        green_next = onehot(dir_next);
        red_next   = ~onehot(dir_next);
      end
      YELLOW: begin
        yellow_next = onehot(dir_next);
        red_next    = ~onehot(dir_next);
      end
      FLASH: begin
        yellow_next = {N_DIR{phase_next}};
        blank_next  = 1'b1;
      end
      default: red_next = '1;
    endcase
  end

  assign green_now = (state_reg == GREEN) ? onehot(dir_reg) : '0;
  assign clr_mask  = (state_next == GREEN && state_reg != GREEN) ? onehot(dir_next) : '0;

  generate
    for (genvar gi = 0; gi < N_DIR; gi++) begin : g_pending
      assign pending_next[gi] = ~clr_mask[gi] &
                                (pending_reg[gi] | (bus.req[gi] & ~green_now[gi]));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ALLRED;
      cnt_reg     <= CNT_W'(ALLRED_S);
      dir_reg     <= 2'(N_DIR - 1);
      phase_reg   <= 1'b0;
      pending_reg <= '0;
      red_reg     <= '1;
      yellow_reg  <= '0;
      green_reg   <= '0;
      blank_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      dir_reg     <= dir_next;
      phase_reg   <= phase_next;
      pending_reg <= pending_next;
      red_reg     <= red_next;
      yellow_reg  <= yellow_next;
      green_reg   <= green_next;
      blank_reg   <= blank_next;
    end
  end

  assign bus.red        = red_reg;
  assign bus.yellow     = yellow_reg;
  assign bus.green      = green_reg;
  assign bus.active_dir = dir_reg;
  assign bus.countdown  = cnt_reg;
  assign bus.blank      = blank_reg;
endmodule

// File: tb/tb_traffic_ctrl_multi.sv
// Bench for traffic_ctrl_multi: a 2-way and a 4-way instance run side by side,
// compared every cycle against a phase/timer reference model, plus directed scenarios.
module tb_traffic_ctrl_multi;
  localparam int GS = 20, YS = 3, AS = 2;
  localparam int P_AR = 0, P_G = 1, P_Y = 2, P_FL = 3;

  logic       clk = 1'b0;
  logic       rst, tick, night;
  logic [3:0] req;
  int         checks = 0, errors = 0;

  always #5 clk = ~clk;

  traffic_ctrl_multi_if #(.N_DIR(2), .CNT_W(6)) bus2 ();
  traffic_ctrl_multi_if #(.N_DIR(4), .CNT_W(6)) bus4 ();

  assign bus2.tick  = tick;
  assign bus2.req   = req[1:0];
  assign bus2.night = night;
  assign bus4.tick  = tick;
  assign bus4.req   = req;
  assign bus4.night = night;

  traffic_ctrl_multi #(.N_DIR(2), .GREEN_S(GS), .YELLOW_S(YS), .ALLRED_S(AS), .CNT_W(6))
    dut2 (.clk(clk), .rst(rst), .bus(bus2));
  traffic_ctrl_multi #(.N_DIR(4), .GREEN_S(GS), .YELLOW_S(YS), .ALLRED_S(AS), .CNT_W(6))
    dut4 (.clk(clk), .rst(rst), .bus(bus4));

  // Reference model: u=0 is the 2-way instance, u=1 the 4-way instance.
  int       nd[2] = '{2, 4};
  int       m_ph[2], m_left[2], m_dir[2];
  bit       m_flash_on[2];
  bit [3:0] m_pend[2];

  function automatic bit [3:0] dir_mask(int u);
    return (nd[u] == 4) ? 4'hF : 4'h3;
  endfunction

  task automatic model_step(int u);
    bit [3:0] r, gm, np, pe;
    int       pick;
    r = req & dir_mask(u);
    if (rst) begin
      m_ph[u] = P_AR; m_left[u] = AS; m_dir[u] = nd[u] - 1;
      m_pend[u] = '0; m_flash_on[u] = 1'b0;
      return;
    end
    gm = (m_ph[u] == P_G) ? (4'b0001 << m_dir[u]) : 4'b0000;
    np = m_pend[u] | (r & ~gm);
    pe = m_pend[u] | r;
    if (tick) begin
      if (m_ph[u] == P_FL) begin
        if (!night) begin
          m_ph[u] = P_AR; m_left[u] = AS; m_flash_on[u] = 1'b0;
        end else begin
          m_flash_on[u] = !m_flash_on[u];
        end
      end else if (m_left[u] > 1) begin
        m_left[u]--;
      end else if (m_ph[u] == P_G) begin
        m_ph[u] = P_Y; m_left[u] = YS;
      end else if (m_ph[u] == P_Y) begin
        m_ph[u] = P_AR; m_left[u] = AS;
      end else if (night) begin
        m_ph[u] = P_FL; m_left[u] = 0; m_flash_on[u] = 1'b0;
      end else begin
        pick = (m_dir[u] + 1) % nd[u];
        for (int k = 1; k <= nd[u]; k++) begin
          if (pe[(m_dir[u] + k) % nd[u]]) begin
            pick = (m_dir[u] + k) % nd[u];
            break;
          end
        end
        m_dir[u] = pick; m_ph[u] = P_G; m_left[u] = GS;
        np[pick] = 1'b0;
      end
    end
    m_pend[u] = np;
  endtask

  task automatic chk(string tag, int u, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, nd[u], obs, exp);
    end
  endtask

  task automatic check_unit(int u, logic [3:0] red, logic [3:0] yel, logic [3:0] grn,
                            logic [1:0] ad, logic [5:0] cd, logic bl);
    bit [3:0] er, ey, eg, oh, mk;
    mk = dir_mask(u);
    oh = 4'b0001 << m_dir[u];
    er = '0; ey = '0; eg = '0;
    case (m_ph[u])
      P_AR: er = mk;
      P_G:  begin eg = oh; er = mk & ~oh; end
      P_Y:  begin ey = oh; er = mk & ~oh; end
      default: ey = m_flash_on[u] ? mk : 4'h0;
    endcase
    chk("red", u, red, er);
    chk("yellow", u, yel, ey);
    chk("green", u, grn, eg);
    chk("active_dir", u, ad, m_dir[u]);
    chk("countdown", u, cd, m_left[u]);
    chk("blank", u, bl, m_ph[u] == P_FL);
    if (bl !== 1'b1) begin
      chk("inv_onehot", u, $countones(yel | grn) <= 1, 1);
      chk("inv_g_and_y", u, |(yel & grn), 0);
      chk("inv_cd_range", u, (cd >= 1) && (cd <= GS), 1);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    check_unit(0, {2'b00, bus2.red}, {2'b00, bus2.yellow}, {2'b00, bus2.green},
               bus2.active_dir, bus2.countdown, bus2.blank);
    check_unit(1, bus4.red, bus4.yellow, bus4.green,
               bus4.active_dir, bus4.countdown, bus4.blank);
  endtask

  // One tick period: idle clocks followed by a single tick-wide clock.
  task automatic tick_run(int clks);
    for (int i = 0; i < clks - 1; i++) cycle();
    tick = 1'b1;
    cycle();
    tick = 1'b0;
  endtask

  initial begin
    int cd0, n;
    rst = 1'b1; tick = 1'b0; night = 1'b0; req = 4'h0;
    cycle();
    cycle();
    chk("rst_red", 0, bus2.red, 2'b11);
    chk("rst_cd", 0, bus2.countdown, AS);
    chk("rst_dir", 0, bus2.active_dir, 1);
    chk("rst_dir", 1, bus4.active_dir, 3);
    rst = 1'b0;

    // Basic N_DIR=2 sequence with ticks every 10 clocks.
    repeat (2) tick_run(10);
    chk("seq_green0", 0, bus2.green, 2'b01);
    chk("seq_cd20", 0, bus2.countdown, GS);
    repeat (GS) tick_run(10);
    chk("seq_yellow0", 0, bus2.yellow, 2'b01);
    repeat (YS) tick_run(10);
    chk("seq_allred", 0, bus2.red, 2'b11);
    repeat (AS) tick_run(10);
    chk("seq_green1", 0, bus2.green, 2'b10);

    // Skip test on the 4-way instance.
    n = 0;
    while (bus4.green != 4'b0001 && n < 200) begin tick_run(4); n++; end
    chk("skip_wait_g0", 1, bus4.green, 4'b0001);
    req = 4'b0100;
    cycle();
    req = 4'h0;
    n = 0;
    while ((bus4.green == 4'b0000 || bus4.green == 4'b0001) && n < 200) begin tick_run(4); n++; end
    chk("skip_to_dir2", 1, bus4.green, 4'b0100);
    n = 0;
    while ((bus4.green == 4'b0000 || bus4.green == 4'b0100) && n < 200) begin tick_run(4); n++; end
    chk("skip_then_dir3", 1, bus4.green, 4'b1000);

    // Night requested mid-green: the green phase still runs out fully.
    repeat (5) tick_run(4);
    night = 1'b1;
    cd0 = int'(bus4.countdown);
    n = 0;
    while (bus4.blank !== 1'b1 && n < 60) begin tick_run(4); n++; end
    chk("night_ticks", 1, n, cd0 + YS + AS);
    chk("flash_red", 1, bus4.red, 4'h0);
    tick_run(4);
    chk("flash_on", 1, bus4.yellow, 4'hF);
    tick_run(4);
    chk("flash_off", 1, bus4.yellow, 4'h0);

    // Night release resumes round-robin after dir 3.
    night = 1'b0;
    tick_run(4);
    chk("release_red", 1, bus4.red, 4'hF);
    chk("release_cd", 1, bus4.countdown, AS);
    repeat (AS) tick_run(4);
    chk("release_green", 1, bus4.green, 4'b0001);

    // Reset coincident with a tick during yellow.
    n = 0;
    while (bus4.yellow == 4'h0 && n < 60) begin tick_run(4); n++; end
    chk("reset_wait_y", 1, bus4.yellow != 4'h0, 1);
    cycle();
    rst = 1'b1; tick = 1'b1;
    cycle();
    rst = 1'b0; tick = 1'b0;
    chk("mid_rst_red", 1, bus4.red, 4'hF);
    chk("mid_rst_cd", 1, bus4.countdown, AS);
    chk("mid_rst_dir", 1, bus4.active_dir, 3);
    chk("mid_rst_dir", 0, bus2.active_dir, 1);

    // Random run against the model, with the invariants checked every cycle.
    for (int i = 0; i < 6000; i++) begin
      tick = ($urandom_range(0, 3) == 0);
      req  = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
      if ($urandom_range(0, 499) == 0) night = !night;
      rst  = ($urandom_range(0, 2999) == 0);
      cycle();
    end
    rst = 1'b0; tick = 1'b0; req = 4'h0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/traffic_ctrl_multi.md
# traffic_ctrl_multi

Parametrised multi-approach traffic-light controller that generalises the single-approach red/green/yellow sequencer to N_DIR conflicting directions. It adds an all-red clearance interval, round-robin arbitration with demand skipping, and a flashing-yellow night mode. It sits between the 1 Hz tick generator and the LED/7-segment drivers. It exports per-direction lamp vectors, the active direction, and a seconds countdown for the display multiplexer.

## Interface
- N_DIR, 2: number of approaches; legal range 2..4
- GREEN_S, 20: green duration in ticks; must be ≥1
- YELLOW_S, 3: yellow duration in ticks; must be ≥1
- ALLRED_S, 2: all-red clearance in ticks; must be ≥1
- CNT_W, 6: countdown width; must hold max(GREEN_S, YELLOW_S, ALLRED_S)

Ports:
- clk  in  1  system clock (50 MHz)
- rst  in  1  reset; synchronous, active-high
- tick  in  1  one-clk-wide 1 Hz pulse
- req  in  N_DIR  per-direction demand, level or pulse; sampled every clk
- night  in  1  night-mode request, level
- red  out  N_DIR  red lamp per direction, 1 = on
- yellow  out  N_DIR  yellow lamp per direction, 1 = on
- green  out  N_DIR  green lamp per direction, 1 = on
- active_dir  out  2  direction currently or last granted green
- countdown  out  CNT_W  ticks remaining in the current state
- blank  out  1  1 = display should blank (night mode)

## Operation
- States: ALLRED, GREEN, YELLOW, FLASH.
- Reset values:
  - state = ALLRED, countdown = ALLRED_S, active_dir = N_DIR-1.
  - red = all 1, yellow = 0, green = 0, blank = 0.
  - pending = 0, flash phase = 0.
- Countdown is loaded with the state duration on state entry and decremented on each tick. When a tick arrives with countdown = 1, the block transitions instead of decrementing. Countdown never reads 0 outside FLASH.
- GREEN: green[active_dir] = 1; every other direction shows red. Exits to YELLOW.
- YELLOW: yellow[active_dir] = 1; every other direction shows red. Exits to ALLRED.
- ALLRED: red on every direction.
  - On exit with night = 1: go to FLASH.
  - Otherwise: go to GREEN with a newly selected active_dir.
- Direction selection:
  - Scan (active_dir+1) mod N_DIR upward with wrap, and take the first direction whose pending bit is set.
  - If no bit is set, take (active_dir+1) mod N_DIR (plain cycling).
  - The current active_dir is considered last.
- pending[i]:
  - Set when req[i] = 1, except while direction i is in GREEN.
  - Cleared on the cycle direction i enters GREEN; the clear wins over a simultaneous req.
- night:
  - In GREEN or YELLOW, night is honoured only at the ALLRED exit. It never truncates a phase.
- FLASH:
  - red = 0, green = 0, blank = 1, countdown = 0.
  - yellow = {N_DIR{phase}}; phase toggles on every tick.
  - Exit on a tick with night = 0 → ALLRED (countdown = ALLRED_S, phase = 0, blank = 0). active_dir is unchanged, so round-robin resumes.
- Safety invariant: at most one green or yellow bit is set outside FLASH, and never green and yellow together.

## Timing
- All outputs are registered. A tick sampled at edge k produces the state change and countdown update visible after edge k; there is no further latency.
- req is sampled at every edge; a pulse of one clk cycle is sufficient to set pending.
- Reset asserted mid-operation restores the reset values at the next edge. A tick or req on that same edge is ignored.
- ALLRED → GREEN selection uses the pending value as of the transition edge, including a req arriving on that same cycle.
- Cycle length with every direction requesting: N_DIR × (GREEN_S + YELLOW_S + ALLRED_S) ticks.

## Test plan
- Reset, N_DIR = 2, defaults, no req, night = 0, ticks every 10 clk:
  - After 2 ticks: green = 01, countdown = 20.
  - After 20 more ticks: yellow = 01.
  - After 3 more: red = 11.
  - After 2 more: green = 10.
- Skip test, N_DIR = 4:
  - Pulse req[2] for one clk during dir 0 green.
  - After dir 0's all-red, the next green is dir 2, not dir 1, and pending[2] reads 0 afterwards.
- Night during GREEN:
  - Assert night mid-green. Green runs its full 20 ticks, then yellow 3 and all-red 2.
  - Then FLASH: yellow alternates between all-1 and all-0 on each tick, blank = 1, red = 0.
- Night release:
  - Deassert night in FLASH. On the next tick: ALLRED with countdown = 2.
  - After 2 ticks: green on (active_dir+1) mod N_DIR.
- Mid-phase reset:
  - Assert rst for 1 clk, coincident with a tick, during YELLOW.
  - Next cycle: red = all 1, countdown = ALLRED_S, active_dir = N_DIR-1.
- Continuous checker over a random req/night/tick run: the safety invariant holds, and countdown stays within 1..duration outside FLASH.
